// File: rtl/mode_transition_arbiter.sv
// Table-driven mode arbiter: fixed-priority toggle resolution against a permission
// mask, per-mode timed auto-return, lock input and a saturating dwell-seconds counter.
module mode_transition_arbiter #(
    parameter int NUM_MODES  = 7,
    parameter int MODE_WIDTH = 8,
    parameter int CNT_WIDTH  = 8,
    parameter int RESET_MODE = 0,
    // Row src occupies bits [src*NUM_MODES +: NUM_MODES]; bit dst within the row permits src->dst.
    parameter logic [NUM_MODES*NUM_MODES-1:0] ALLOW_MASK = {
        7'h03,   // SET    -> OFF, STAND
        7'h03,   // CLEAN  -> OFF, STAND
        7'h0B,   // THIRD  -> OFF, STAND, SECOND
        7'h07,   // SECOND -> OFF, STAND, FIRST
        7'h0B,   // FIRST  -> OFF, STAND, SECOND
        7'h7D,   // STAND  -> all but itself
        7'h02    // OFF    -> STAND
    },
    parameter logic [NUM_MODES*CNT_WIDTH-1:0] TIMEOUT_VEC = {
        8'd0, 8'd180, 8'd60, 8'd0, 8'd0, 8'd0, 8'd0
    },
    parameter logic [NUM_MODES*MODE_WIDTH-1:0] TARGET_VEC = {
        8'd0, 8'd1, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0
    }
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  tick_1s,
    input  logic [NUM_MODES-1:0]  mode_toggle,
    input  logic                  mode_lock,
    output logic [MODE_WIDTH-1:0] current_mode,
    output logic [MODE_WIDTH-1:0] previous_mode,
    output logic                  mode_changed,
    output logic                  timeout_pulse,
    output logic                  reject_pulse,
    output logic [CNT_WIDTH-1:0]  dwell_seconds
);

    localparam logic [MODE_WIDTH-1:0] RESET_M   = MODE_WIDTH'(RESET_MODE);
    localparam logic [MODE_WIDTH-1:0] LAST_M    = MODE_WIDTH'(NUM_MODES - 1);
    localparam logic [CNT_WIDTH-1:0]  DWELL_MAX = '1;

    logic                  illegal;
    int                    cur_idx;
    logic                  win_vld;
    logic [MODE_WIDTH-1:0] win_mode;
    logic                  rej;
    logic [CNT_WIDTH-1:0]  tmo_limit;
    logic [MODE_WIDTH-1:0] tmo_target;
    logic                  tmo_fire;

    logic [MODE_WIDTH-1:0] mode_nxt;
    logic [MODE_WIDTH-1:0] prev_nxt;
    logic [CNT_WIDTH-1:0]  dwell_nxt;
    logic                  changed_nxt;
    logic                  tmo_nxt;
    logic                  rej_nxt;

    always_comb begin
        illegal  = (current_mode > LAST_M);
        cur_idx  = illegal ? 0 : int'(current_mode);
        win_vld  = 1'b0;
        win_mode = RESET_M;
        rej      = 1'b0;
        // Scan high to low so the lowest-index allowed request is the one left standing.
        for (int d = NUM_MODES - 1; d >= 0; d--) begin
            if (mode_toggle[d] && (d != cur_idx)) begin
                if (ALLOW_MASK[cur_idx*NUM_MODES + d] && (!mode_lock || (d == 0))) begin
                    win_vld  = 1'b1;
                    win_mode = MODE_WIDTH'(d);
                end else begin
                    rej = 1'b1;
                end
            end
        end

        tmo_limit  = TIMEOUT_VEC[cur_idx*CNT_WIDTH +: CNT_WIDTH];
        tmo_target = TARGET_VEC[cur_idx*MODE_WIDTH +: MODE_WIDTH];
        tmo_fire   = !win_vld && tick_1s && (tmo_limit != '0) &&
                     (dwell_seconds == tmo_limit - CNT_WIDTH'(1));

        mode_nxt    = current_mode;
        prev_nxt    = previous_mode;
        dwell_nxt   = dwell_seconds;
        changed_nxt = 1'b0;
        tmo_nxt     = 1'b0;
        rej_nxt     = 1'b0;

        if (illegal) begin
            mode_nxt    = RESET_M;
            prev_nxt    = current_mode;
            dwell_nxt   = '0;
            changed_nxt = 1'b1;
        end else begin
            rej_nxt = rej;
            if (win_vld) begin
                mode_nxt    = win_mode;
                prev_nxt    = current_mode;
                dwell_nxt   = '0;
                changed_nxt = 1'b1;
            end else if (tmo_fire) begin
                mode_nxt    = tmo_target;
                prev_nxt    = current_mode;
                dwell_nxt   = '0;
                changed_nxt = 1'b1;
                tmo_nxt     = 1'b1;
            end else if (tick_1s && (dwell_seconds != DWELL_MAX)) begin
                dwell_nxt = dwell_seconds + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            current_mode  <= RESET_M;
            previous_mode <= RESET_M;
            dwell_seconds <= '0;
            mode_changed  <= 1'b0;
            timeout_pulse <= 1'b0;
            reject_pulse  <= 1'b0;
        end else begin
            current_mode  <= mode_nxt;
            previous_mode <= prev_nxt;
            dwell_seconds <= dwell_nxt;
            mode_changed  <= changed_nxt;
            timeout_pulse <= tmo_nxt;
            reject_pulse  <= rej_nxt;
        end
    end

endmodule

// File: doc/mode_transition_arbiter.md
Name: mode_transition_arbiter

Overview:
- Parametrised, table-driven replacement for the hand-coded mode case statement in the hood top level.
- Accepts one single-cycle toggle per mode from the per-mode controllers and resolves simultaneous requests by fixed priority.
- Checks each request against a source-to-destination permission mask and commits one registered mode change per cycle.
- Adds features the current top does not have: per-mode timed auto-return, a lock input, reject/change/timeout pulses, and a dwell-seconds counter for the display logic.

Parameters:
- NUM_MODES, 7, number of modes; index 0 = OFF, 1 = STAND, 2 = FIRST, 3 = SECOND, 4 = THIRD, 5 = CLEAN, 6 = SET.
- MODE_WIDTH, 8, width of mode index outputs; must satisfy 2^MODE_WIDTH >= NUM_MODES.
- CNT_WIDTH, 8, width of the dwell-seconds counter and of the timeout fields.
- RESET_MODE, 0, mode loaded on reset and on illegal state.
- ALLOW_MASK, NUM_MODES*NUM_MODES bits. Bit [src*NUM_MODES+dst] = 1 permits src->dst. Default matrix:
  - OFF->STAND
  - STAND->{OFF, FIRST, SECOND, THIRD, CLEAN, SET}
  - FIRST->{OFF, STAND, SECOND}
  - SECOND->{OFF, STAND, FIRST}
  - THIRD->{OFF, STAND, SECOND}
  - CLEAN->{OFF, STAND}
  - SET->{OFF, STAND}
- TIMEOUT_VEC, NUM_MODES*CNT_WIDTH bits. Field m = seconds before auto-exit from mode m; 0 = no timeout. Default: THIRD = 60, CLEAN = 180, all others 0.
- TARGET_VEC, NUM_MODES*MODE_WIDTH bits. Field m = auto-exit destination of mode m. Default: THIRD->SECOND, CLEAN->STAND. A target need not be in ALLOW_MASK.

Ports:
- clk, input, 1, system clock.
- rstn, input, 1, asynchronous active-low reset.
- tick_1s, input, 1, one-cycle pulse once per second.
- mode_toggle, input, NUM_MODES, bit d = request to enter mode d; each bit is a one-cycle pulse.
- mode_lock, input, 1, level; while high only the OFF request is honoured.
- current_mode, output, MODE_WIDTH, registered active mode index.
- previous_mode, output, MODE_WIDTH, mode active before the last change.
- mode_changed, output, 1, one-cycle pulse in the cycle current_mode takes its new value.
- timeout_pulse, output, 1, one-cycle pulse when an auto-exit commits.
- reject_pulse, output, 1, one-cycle pulse when at least one asserted toggle was refused.
- dwell_seconds, output, CNT_WIDTH, whole seconds spent in the current mode.

Behaviour:
- Reset (async, rstn low):
  - current_mode = previous_mode = RESET_MODE.
  - dwell_seconds = 0.
  - mode_changed, timeout_pulse, reject_pulse = 0.
- Latency: toggles are sampled at a rising edge; the new mode is visible after that same edge. Exactly one cycle from request to output. No combinational input-to-output path.
- Candidate set per cycle: asserted bits d where d != current_mode and ALLOW_MASK[current_mode*NUM_MODES+d] = 1.
- While mode_lock = 1, the candidate set is restricted to d = 0.
- Priority: the lowest-index candidate wins, so OFF beats STAND beats FIRST, and so on.
- Reject rule:
  - reject_pulse = 1 if any asserted toggle bit d != current_mode is not the winner and was excluded by the mask or the lock.
  - Losing-but-allowed candidates do NOT raise reject_pulse.
  - A toggle for the current mode is silently ignored.
- Timeout:
  - Applies when the current mode's TIMEOUT field T != 0.
  - Fires when tick_1s = 1 and dwell_seconds == T-1, provided no toggle candidate wins that cycle.
  - On firing: current_mode <= target, timeout_pulse = 1.
  - Timeout is honoured even when mode_lock = 1.
- Commit, on any change:
  - previous_mode <= old current_mode.
  - mode_changed = 1.
  - dwell_seconds <= 0; the tick is not counted in that cycle.
- Dwell counter: otherwise increments on tick_1s and saturates at 2^CNT_WIDTH-1, with no wrap.
- Precedence in one cycle: winning toggle > timeout > hold.
- Illegal state: if current_mode >= NUM_MODES, the next edge forces RESET_MODE.
  - mode_changed = 1; reject_pulse and timeout_pulse = 0.
- Reset mid-dwell or mid-timeout cancels everything immediately; no pending state survives.

Test Plan:
- Release reset, then pulse toggle[1] -> next cycle current_mode = 1, previous_mode = 0, mode_changed = 1, dwell_seconds = 0.
- In STAND, pulse toggle[2] and toggle[3] together -> current_mode = 2, reject_pulse = 0. Then in FIRST pulse toggle[5] -> mode stays 2, reject_pulse = 1.
- Enter THIRD (1->4), then apply 60 tick_1s pulses -> after the 60th, current_mode = 3, timeout_pulse = 1, dwell_seconds = 0.
  - Repeat with toggle[1] on the 60th tick -> current_mode = 1, timeout_pulse = 0.
- In FIRST with mode_lock = 1, pulse toggle[3] -> mode stays 2, reject_pulse = 1. Then pulse toggle[0] -> current_mode = 0, mode_changed = 1.
- Stay in STAND for 300 ticks with CNT_WIDTH = 8 -> dwell_seconds saturates at 255.
- Assert rstn low for one cycle at 100 ticks into CLEAN -> current_mode = 0 and dwell_seconds = 0 immediately. No timeout_pulse follows after 80 further ticks.
